// File: rtl/mem_rd_sched_pkg.sv
// Shared types, default parameters and the round-robin pick helper for the
// mem_rd_sched read scheduler.
package mem_rd_sched_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int AW_DEF        = 8;
    localparam int DW_DEF        = 8;
    localparam int RD_CYCLES_DEF = 2;

    // The helper works on the widest supported requester count; callers
    // zero-extend their vectors into this width.
    localparam int MAX_REQ = 8;
    localparam int MAX_PW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } rd_state_e;

    // Returns the first set request at or above ptr, wrapping at n_req.
    // The search runs from the farthest offset down to offset 0 so that the
    // nearest requester overwrites any farther one. With no request set the
    // result is ptr and is meaningless.
    function automatic logic [MAX_PW-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [MAX_PW-1:0]  ptr,
        input int                 n_req
    );
        logic [MAX_PW-1:0] pick;
        logic [MAX_PW-1:0] idx3;
        int                idx;
        pick = ptr;
        for (int off = MAX_REQ - 1; off >= 0; off--) begin
            idx  = (int'(ptr) + off) % n_req;
            idx3 = idx[MAX_PW-1:0];
            if ((off < n_req) && req[idx3]) begin
                pick = idx3;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_rd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the winning requester index from
// the request vector and the rotating priority pointer.
module rr_arbiter
    import mem_rd_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PW    = 2
)(
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    winner_o,
    output logic             any_o
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_PW-1:0]  ptr_ext;
    logic [MAX_PW-1:0]  pick;

    // Widen request and pointer to the helper's fixed width, then pick
    always_comb begin
        req_ext             = '0;
        req_ext[N_REQ-1:0]  = req_i;
        ptr_ext             = '0;
        ptr_ext[PW-1:0]     = ptr_i;
        pick                = rr_pick(req_ext, ptr_ext, N_REQ);
    end

    assign winner_o = PW'(pick);
    assign any_o    = |req_i;

endmodule

// File: rtl/mem_rd_sched.sv
// Round-robin read scheduler sharing one single-port memory read interface
// among N_REQ requesters. Each grant becomes one read transaction with rd
// held for RD_CYCLES cycles and a stable address, followed by a one-cycle
// response back to the winner.
// Optional protocol checkers: define MEM_RD_SCHED_ASSERT_EN.
module mem_rd_sched
    import mem_rd_sched_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                ce,
    output logic                rd,
    output logic [AW-1:0]       addr,
    input  logic [DW-1:0]       rdata
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(RD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

    rd_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              ce_q, ce_d;
    logic              rd_q, rd_d;
    logic [AW-1:0]     addr_q, addr_d;

    logic [PW-1:0]     arb_win;
    logic              arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (arb_win),
        .any_o    (arb_any)
    );

    // State, counter, pointer and all registered outputs; reset drops any
    // in-flight transaction without producing a response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            win_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            ce_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ce_q        <= ce_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
        end
    end

    // Next state: arbitrate when idle or responding, otherwise run the strobe
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RSP: state_d = arb_any ? RD : IDLE;
            RD:        if (cnt_q == CNT_LAST) state_d = RSP;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the datapath registers
    always_comb begin
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        ce_d        = 1'b0;
        rd_d        = 1'b0;
        addr_d      = addr_q;
        case (state_q)
            IDLE, RSP: begin
                if (arb_any) begin
                    gnt_d[arb_win] = 1'b1;
                    addr_d         = req_addr[arb_win*AW +: AW];
                    cnt_d          = '0;
                    win_d          = arb_win;
                    ptr_d          = (arb_win == PTR_LAST) ? '0 : arb_win + PW'(1);
                    ce_d           = 1'b1;
                    rd_d           = 1'b1;
                end
            end
            RD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d         = rdata;
                    rsp_valid_d[win_q] = 1'b1;
                end else begin
                    ce_d = 1'b1;
                    rd_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign ce        = ce_q;
    assign rd        = rd_q;
    assign addr      = addr_q;

`ifdef MEM_RD_SCHED_ASSERT_EN
    logic          rd_prev_q;
    logic [AW-1:0] addr_prev_q;
    logic [7:0]    rd_run_q;

    // Remember the previous rd/addr and count the length of the current rd run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_prev_q   <= 1'b0;
            addr_prev_q <= '0;
            rd_run_q    <= '0;
        end else begin
            rd_prev_q   <= rd;
            addr_prev_q <= addr;
            rd_run_q    <= rd ? rd_run_q + 8'd1 : 8'd0;
        end
    end

    a_rd_len: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_prev_q && !rd) |-> (rd_run_q == 8'(RD_CYCLES)));

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rd && rd_prev_q) |-> (addr == addr_prev_q));

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));

    a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));

    a_rd_ce: assert property (@(posedge clk) disable iff (!rst_n)
        rd |-> ce);
`endif

endmodule
